// File: rtl/encode.sv
// Hamming single-error-correcting encoder: two-stage valid/ready pipeline that emits
// codewords (parity at power-of-two positions) XORed with a per-word fault-injection mask.
`timescale 1ns/1ps
module encode #(
  parameter int unsigned data_width     = 16,
  parameter int unsigned encoding_width = 21
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [data_width-1:0]     data_in,
  input  logic [encoding_width-1:0] err_inject,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [encoding_width-1:0] encoded_data,
  output logic [15:0]               word_count
);

  localparam int unsigned ParityBits = encoding_width - data_width;

  if (encoding_width <= data_width ||
      (64'd1 << ParityBits) < (64'(encoding_width) + 64'd1)) begin : g_bad_width
    $error("encode: encoding_width must be data_width + r with 2^r >= data_width + r + 1");
  end

  // Hamming positions (1-based) whose index has bit k set.
  function automatic logic [encoding_width-1:0] cover_mask(input int unsigned k);
    logic [encoding_width-1:0] m;
    m = '0;
    for (int unsigned p = 1; p <= encoding_width; p++) begin
      if (((p >> k) & 32'd1) != 32'd0) m[p-1] = 1'b1;
    end
    return m;
  endfunction

  logic                      r_s1_v;
  logic [data_width-1:0]     r_s1_data;
  logic [encoding_width-1:0] r_s1_mask;
  logic                      r_valid_out;
  logic [encoding_width-1:0] r_encoded;
  logic [15:0]               r_word_count;

  logic                      w_s2_adv;
  logic                      w_s1_accept;
  logic [encoding_width-1:0] w_code;

  assign w_s2_adv    = !r_valid_out || ready_out;
  assign ready_in    = !r_s1_v || w_s2_adv;
  assign w_s1_accept = valid_in && ready_in;

  always_comb begin
    int unsigned w_di;
    w_code = '0;
    w_di   = 0;
    for (int unsigned p = 1; p <= encoding_width; p++) begin
      if ((p & (p - 32'd1)) != 32'd0) begin
        w_code[p-1] = r_s1_data[w_di];
        w_di++;
      end
    end
    // Parity slots are still zero here, so each XOR covers data bits only.
    for (int unsigned k = 0; k < ParityBits; k++) begin
      w_code[(32'd1 << k) - 32'd1] = ^(w_code & cover_mask(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_mask <= '0;
    end else if (w_s1_accept) begin
      r_s1_v    <= 1'b1;
      r_s1_data <= data_in;
      r_s1_mask <= err_inject;
    end else if (w_s2_adv) begin
      r_s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_out  <= 1'b0;
      r_encoded    <= '0;
      r_word_count <= '0;
    end else begin
      if (w_s2_adv) begin
        r_valid_out <= r_s1_v;
        if (r_s1_v) r_encoded <= w_code ^ r_s1_mask;
      end
      if (r_valid_out && ready_out) r_word_count <= r_word_count + 16'd1;
    end
  end

  assign valid_out    = r_valid_out;
  assign encoded_data = r_encoded;
  assign word_count   = r_word_count;

endmodule

// File: tb/tb_encode.sv
// Directed and scoreboard bench for the Hamming encoder pipeline.
`timescale 1ns/1ps
module tb_encode;

  localparam int unsigned DW = 16;
  localparam int unsigned EW = 21;
  localparam int unsigned NumRand = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] data_in;
  logic [EW-1:0] err_inject;
  logic          valid_out;
  logic          ready_out;
  logic [EW-1:0] encoded_data;
  logic [15:0]   word_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  encode #(
    .data_width    (DW),
    .encoding_width(EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .data_in     (data_in),
    .err_inject  (err_inject),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .encoded_data(encoded_data),
    .word_count  (word_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: parity bits are the syndrome of the data-only word.
  function automatic logic [EW-1:0] ref_enc(input logic [DW-1:0] d);
    logic [EW-1:0] c;
    logic [4:0]    syn;
    int            j;
    c   = '0;
    syn = '0;
    j   = 0;
    for (int p = 1; p <= int'(EW); p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        if (d[j]) syn ^= 5'(p);
        j++;
      end
    end
    for (int k = 0; k < 5; k++) c[(1 << k) - 1] = syn[k];
    return c;
  endfunction

  function automatic logic [DW-1:0] ref_dec(input logic [EW-1:0] cw);
    logic [EW-1:0] c;
    logic [DW-1:0] d;
    logic [4:0]    syn;
    int            j;
    c   = cw;
    syn = '0;
    for (int p = 1; p <= int'(EW); p++) if (c[p-1]) syn ^= 5'(p);
    if (syn != 5'd0 && int'(syn) <= int'(EW)) c[int'(syn) - 1] = ~c[int'(syn) - 1];
    d = '0;
    j = 0;
    for (int p = 1; p <= int'(EW); p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p-1];
        j++;
      end
    end
    return d;
  endfunction

  // Called #1 after a clock edge with an empty pipeline and ready_out=1.
  task automatic send_one(input logic [DW-1:0] d, input logic [EW-1:0] m,
                          output logic [EW-1:0] got, output int lat);
    valid_in   = 1'b1;
    data_in    = d;
    err_inject = m;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat      = 1;
    while (!valid_out && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    got = encoded_data;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] held;
    logic [EW-1:0] last;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] s_words[4];
    logic [EW-1:0] s_codes[4];
    logic [EW-1:0] b2b_codes[3];
    logic [DW-1:0] b2b_words[3];
    int            lat;
    int            idx_in;
    int            idx_out;
    int            n_acc;
    int            n_out;
    int            guard;
    int            sent;
    int            rcvd;
    bit            accepted;
    bit            stall_prev;

    rst        = 1'b1;
    valid_in   = 1'b0;
    ready_out  = 1'b0;
    data_in    = '0;
    err_inject = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid_out", 32'(valid_out), 32'd0);
    check_eq("rst_encoded", 32'(encoded_data), 32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ready_in", 32'(ready_in), 32'd1);
    check_eq("rst_idle_valid", 32'(valid_out), 32'd0);

    // Single word, two-edge latency
    ready_out = 1'b1;
    send_one(16'd10, '0, got, lat);
    check_eq("enc_10", 32'(got), 32'd82);
    check_eq("lat_10", 32'(lat), 32'd2);
    check_eq("count_1", 32'(word_count), 32'd1);

    // Back-to-back words
    b2b_words = '{16'h0000, 16'h0001, 16'hFFFF};
    b2b_codes = '{21'd0, 21'd7, 21'h1FFFFE};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        valid_in = 1'b1;
        data_in  = b2b_words[i];
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk);
      if (i >= 2) check_eq($sformatf("b2b_%0d", i - 2), 32'({valid_out, encoded_data}),
                           32'({1'b1, b2b_codes[i-2]}));
      @(posedge clk); #1;
    end
    check_eq("count_4", 32'(word_count), 32'd4);

    // Error injection and single-bit sweep
    send_one(16'd10, 21'(1 << 6), got, lat);
    check_eq("inject_bit6", 32'(got), 32'd18);
    check_eq("inject_bit6_dec", 32'(ref_dec(got)), 32'd10);
    for (int b = 0; b < int'(EW); b++) begin
      send_one(16'd10, 21'(1 << b), got, lat);
      check_eq($sformatf("sweep_enc_%0d", b), 32'(got), 32'd82 ^ (32'd1 << b));
      check_eq($sformatf("sweep_dec_%0d", b), 32'(ref_dec(got)), 32'd10);
    end
    check_eq("count_26", 32'(word_count), 32'd26);

    // Downstream stall for 5 cycles, then drain in order
    s_words   = '{16'h0001, 16'd10, 16'hFFFF, 16'h0000};
    s_codes   = '{21'd7, 21'd82, 21'h1FFFFE, 21'd0};
    ready_out = 1'b0;
    idx_in    = 0;
    held      = '0;
    valid_in  = 1'b1;
    data_in   = s_words[0];
    err_inject = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) held = encoded_data;
      if (valid_in && ready_in) idx_in++;
      @(posedge clk); #1;
      if (idx_in < 4) data_in = s_words[idx_in];
      else valid_in = 1'b0;
    end
    check_eq("stall_accepts", 32'(idx_in), 32'd2);
    check_eq("stall_ready_in", 32'(ready_in), 32'd0);
    check_eq("stall_valid", 32'(valid_out), 32'd1);
    check_eq("stall_hold", 32'(encoded_data), 32'(held));
    check_eq("stall_word", 32'(encoded_data), 32'd7);
    ready_out = 1'b1;
    idx_out   = 0;
    guard     = 0;
    while (idx_out < 4 && guard < 20) begin
      @(negedge clk);
      if (valid_in && ready_in) idx_in++;
      if (valid_out && ready_out) begin
        check_eq($sformatf("drain_%0d", idx_out), 32'(encoded_data), 32'(s_codes[idx_out]));
        idx_out++;
      end
      @(posedge clk); #1;
      guard++;
      if (idx_in < 4) data_in = s_words[idx_in];
      else valid_in = 1'b0;
    end
    check_eq("drain_count", 32'(idx_out), 32'd4);
    check_eq("count_30", 32'(word_count), 32'd30);

    // Asynchronous reset with both stages full
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 16'hFFFF;
    repeat (3) begin
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    check_eq("full_ready_in", 32'(ready_in), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_valid_out", 32'(valid_out), 32'd0);
    check_eq("arst_encoded", 32'(encoded_data), 32'd0);
    check_eq("arst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    ready_out = 1'b1;
    @(posedge clk); #1;
    send_one(16'd1, '0, got, lat);
    check_eq("post_rst_enc", 32'(got), 32'd7);
    check_eq("post_rst_lat", 32'(lat), 32'd2);
    check_eq("post_rst_count", 32'(word_count), 32'd1);

    // word_count wrap
    n_acc    = 0;
    n_out    = 0;
    guard    = 0;
    valid_in = 1'b1;
    data_in  = '0;
    while (n_out < 65533 && guard < 65560) begin
      @(negedge clk);
      if (valid_in && ready_in) n_acc++;
      if (valid_out && ready_out) n_out++;
      @(posedge clk); #1;
      guard++;
      data_in = 16'(n_acc);
      if (n_acc >= 65533) valid_in = 1'b0;
    end
    valid_in = 1'b0;
    check_eq("count_fffe", 32'(word_count), 32'h0000FFFE);
    send_one(16'd10, '0, got, lat);
    check_eq("count_ffff", 32'(word_count), 32'h0000FFFF);
    send_one(16'd10, '0, got, lat);
    check_eq("count_wrap", 32'(word_count), 32'd0);

    // Random-stall scoreboard
    sent       = 0;
    rcvd       = 0;
    guard      = 0;
    stall_prev = 1'b0;
    last       = '0;
    valid_in   = 1'b0;
    while (rcvd < int'(NumRand) && guard < 20 * int'(NumRand)) begin
      if (!valid_in && sent < int'(NumRand) && $urandom_range(3) != 0) begin
        valid_in   = 1'b1;
        data_in    = DW'($urandom);
        err_inject = ($urandom_range(1) == 0) ? '0 : EW'($urandom);
      end
      ready_out = ($urandom_range(2) != 0);
      @(negedge clk);
      if (stall_prev) check_eq("sb_hold", 32'({valid_out, encoded_data}), 32'({1'b1, last}));
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_spurious", 32'(valid_out), 32'd0);
        end else begin
          check_eq("sb_word", 32'(encoded_data), 32'(exp_q.pop_front()));
        end
        rcvd++;
      end
      accepted = 1'b0;
      if (valid_in && ready_in) begin
        exp_q.push_back(ref_enc(data_in) ^ err_inject);
        sent++;
        accepted = 1'b1;
      end
      stall_prev = valid_out && !ready_out;
      last       = encoded_data;
      @(posedge clk); #1;
      guard++;
      if (accepted) valid_in = 1'b0;
    end
    check_eq("sb_received", 32'(rcvd), NumRand);
    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
